// File: rtl/time_tracker_pkg.sv
// Shared types and constants for the elapsed-time tracker: FSM encoding and BCD limits.
package time_tracker_pkg;

   localparam int unsigned DigitW    = 4;
   localparam logic [15:0] BcdMax    = 16'h9999;
   localparam logic [15:0] BcdPreMax = 16'h9998;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StHold = 2'd2,
      StSat  = 2'd3
   } state_e;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit (0-9) with synchronous clear and increment; carry fires on 9 -> 0.
module bcd_digit_counter
   import time_tracker_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              inc,
   output logic [DigitW-1:0] digit,
   output logic              carry
);

   localparam logic [DigitW-1:0] Nine = DigitW'(9);
   localparam logic [DigitW-1:0] One  = DigitW'(1);

   logic [DigitW-1:0] digit_q, digit_d;

   always_comb begin
      digit_d = digit_q;
      if (clr) begin
         digit_d = '0;
      end else if (inc) begin
         digit_d = (digit_q == Nine) ? '0 : digit_q + One;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         digit_q <= '0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit = digit_q;
   assign carry = inc & (digit_q == Nine);

endmodule

// File: rtl/elapsed_time_tracker.sv
// Game survival timer: prescales 1 ms ticks into 0.1 s steps of a 4-digit BCD count,
// gated by a run/hold/saturate FSM that also enables the upstream millisecond timer.
module elapsed_time_tracker
   import time_tracker_pkg::*;
#(
   parameter int unsigned MS_PER_TENTH = 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ms_tick,
   input  logic        start,
   input  logic        stop,
   input  logic        clear,
   output logic        timer_en,
   output logic [15:0] bcd_time,
   output logic        tenth_pulse,
   output logic        running,
   output logic        saturated
);

   localparam logic [6:0] MsLast = 7'(MS_PER_TENTH - 1);

   state_e     state_q, state_d;
   logic [6:0] ms_cnt_q, ms_cnt_d;
   logic       timer_en_q, timer_en_d;
   logic       tenth_pulse_q, tenth_pulse_d;
   logic       running_q, running_d;
   logic       saturated_q, saturated_d;

   logic        tick_run;
   logic        tenth_inc;
   logic [3:0]  digit_inc;
   logic [3:0]  digit_carry;
   logic [15:0] bcd_digits;
   logic        unused_top_carry;

   // A tick is only consumed in RUN when neither clear nor stop wins this cycle.
   assign tick_run  = (state_q == StRun) & ms_tick & ~clear & ~stop;
   assign tenth_inc = tick_run & (ms_cnt_q == MsLast);

   always_comb begin
      ms_cnt_d = ms_cnt_q;
      if (clear) begin
         ms_cnt_d = '0;
      end else if (tick_run) begin
         ms_cnt_d = tenth_inc ? '0 : ms_cnt_q + 7'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (clear)      state_d = StIdle;
            else if (start) state_d = StRun;
         end
         StRun: begin
            if (clear)                                     state_d = StIdle;
            else if (stop)                                 state_d = StHold;
            else if (tenth_inc && bcd_digits == BcdPreMax) state_d = StSat;
         end
         StHold: begin
            if (clear)      state_d = StIdle;
            else if (stop)  state_d = StHold;
            else if (start) state_d = StRun;
         end
         StSat: begin
            if (clear) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      timer_en_d    = (state_d == StRun);
      running_d     = (state_d == StRun);
      saturated_d   = (state_d == StSat);
      tenth_pulse_d = tenth_inc;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= StIdle;
         ms_cnt_q      <= '0;
         timer_en_q    <= 1'b0;
         tenth_pulse_q <= 1'b0;
         running_q     <= 1'b0;
         saturated_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         ms_cnt_q      <= ms_cnt_d;
         timer_en_q    <= timer_en_d;
         tenth_pulse_q <= tenth_pulse_d;
         running_q     <= running_d;
         saturated_q   <= saturated_d;
      end
   end

   // Ripple carry tenths -> ones -> tens -> hundreds.
   assign digit_inc = {digit_carry[2:0], tenth_inc};

   for (genvar i = 0; i < 4; i++) begin : g_digit
      bcd_digit_counter u_digit (
         .clk   (clk),
         .rst   (rst),
         .clr   (clear),
         .inc   (digit_inc[i]),
         .digit (bcd_digits[i*DigitW +: DigitW]),
         .carry (digit_carry[i])
      );
   end

   // Saturation stops counting at 999.9, so the top carry can never fire.
   assign unused_top_carry = digit_carry[3];

   assign timer_en    = timer_en_q;
   assign bcd_time    = bcd_digits;
   assign tenth_pulse = tenth_pulse_q;
   assign running     = running_q;
   assign saturated   = saturated_q;

endmodule

// File: tb/tb_elapsed_time_tracker.sv
// Bench for elapsed_time_tracker: two instances (4 and 100 ms per tenth) on shared stimulus,
// checked every cycle against an integer-tenths model plus hand-computed literal checks.
module tb_elapsed_time_tracker;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic ms_tick = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;

   logic        en4, pulse4, run4, sat4;
   logic [15:0] bcd4;
   logic        en100, pulse100, run100, sat100;
   logic [15:0] bcd100;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;
   int npulse4 = 0;

   always #10 clk = ~clk;

   elapsed_time_tracker #(.MS_PER_TENTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .ms_tick     (ms_tick),
      .start       (start),
      .stop        (stop),
      .clear       (clear),
      .timer_en    (en4),
      .bcd_time    (bcd4),
      .tenth_pulse (pulse4),
      .running     (run4),
      .saturated   (sat4)
   );

   elapsed_time_tracker #(.MS_PER_TENTH(100)) dut100 (
      .clk         (clk),
      .rst         (rst),
      .ms_tick     (ms_tick),
      .start       (start),
      .stop        (stop),
      .clear       (clear),
      .timer_en    (en100),
      .bcd_time    (bcd100),
      .tenth_pulse (pulse100),
      .running     (run100),
      .saturated   (sat100)
   );

   // Model: state name, ms within the current tenth, and total elapsed tenths as an integer.
   localparam int MIdle = 0, MRun = 1, MHold = 2, MSat = 3;

   typedef struct {
      int st;
      int ms;
      int t;
      bit pulse;
   } mdl_t;

   mdl_t m4   = '{default: 0};
   mdl_t m100 = '{default: 0};

   function automatic mdl_t model_step(mdl_t m, int mpt, logic r, logic tk, logic s, logic p,
                                       logic c);
      mdl_t n = m;
      n.pulse = 1'b0;
      if (!r || c) begin
         n.st = MIdle;
         n.ms = 0;
         n.t  = 0;
      end else begin
         case (m.st)
            MIdle: if (s) n.st = MRun;
            MRun: begin
               if (p) begin
                  n.st = MHold;
               end else if (tk) begin
                  if (m.ms == mpt - 1) begin
                     n.ms    = 0;
                     n.t     = m.t + 1;
                     n.pulse = 1'b1;
                     if (n.t == 9999) n.st = MSat;
                  end else begin
                     n.ms = m.ms + 1;
                  end
               end
            end
            MHold: if (s) n.st = MRun;
            default: ;
         endcase
      end
      return n;
   endfunction

   function automatic logic [15:0] to_bcd(int t);
      return {4'(t / 1000), 4'((t / 100) % 10), 4'((t / 10) % 10), 4'(t % 10)};
   endfunction

   task automatic check(string name, logic [15:0] got, logic [15:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      m4   <= model_step(m4, 4, rst, ms_tick, start, stop, clear);
      m100 <= model_step(m100, 100, rst, ms_tick, start, stop, clear);
      if (pulse4 === 1'b1) npulse4++;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m4_bcd", bcd4, to_bcd(m4.t));
         check("m4_pulse", 16'(pulse4), 16'(m4.pulse));
         check("m4_en", 16'(en4), 16'(m4.st == MRun));
         check("m4_run", 16'(run4), 16'(m4.st == MRun));
         check("m4_sat", 16'(sat4), 16'(m4.st == MSat));
         check("m100_bcd", bcd100, to_bcd(m100.t));
         check("m100_pulse", 16'(pulse100), 16'(m100.pulse));
         check("m100_en", 16'(en100), 16'(m100.st == MRun));
         check("m100_run", 16'(run100), 16'(m100.st == MRun));
         check("m100_sat", 16'(sat100), 16'(m100.st == MSat));
      end
   end

   task automatic step(input logic t, input logic s, input logic p, input logic c);
      @(negedge clk);
      ms_tick = t;
      start   = s;
      stop    = p;
      clear   = c;
   endtask

   task automatic idle(int n);
      repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic ticks(int n);
      repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b0;
      idle(2);
      rst    = 1'b1;
      chk_en = 1'b1;
      check("rst_bcd", bcd4, 16'h0000);
      check("rst_en", 16'(en4), 16'd0);
      check("rst_run", 16'(run4), 16'd0);
      check("rst_sat", 16'(sat4), 16'd0);

      // 1: start, 8 ticks -> 0.2 s with two pulses
      npulse4 = 0;
      step(1'b0, 1'b1, 1'b0, 1'b0);
      idle(1);
      check("t1_en_after_start", 16'(en4), 16'd1);
      check("t1_running", 16'(run4), 16'd1);
      ticks(8);
      idle(2);
      check("t1_bcd", bcd4, 16'h0002);
      check("t1_pulses", 16'(npulse4), 16'd2);

      // 2: ripple carry across two digits
      ticks(388);
      idle(1);
      check("t2_bcd_0099", bcd4, 16'h0099);
      ticks(4);
      idle(1);
      check("t2_bcd_0100", bcd4, 16'h0100);

      // 3: partial ms kept across HOLD, ticks in HOLD dropped
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      ticks(2);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      ticks(10);
      check("t3_en_hold", 16'(en4), 16'd0);
      check("t3_bcd_hold", bcd4, 16'h0000);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      ticks(2);
      idle(1);
      check("t3_bcd_resume", bcd4, 16'h0001);

      // 4: saturation at 999.9
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      ticks(39992);
      idle(1);
      check("t4_bcd_9998", bcd4, 16'h9998);
      check("t4_sat_before", 16'(sat4), 16'd0);
      ticks(4);
      idle(1);
      check("t4_bcd_9999", bcd4, 16'h9999);
      check("t4_sat", 16'(sat4), 16'd1);
      check("t4_en_low", 16'(en4), 16'd0);
      ticks(5);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      idle(1);
      check("t4_bcd_held", bcd4, 16'h9999);
      check("t4_sat_held", 16'(sat4), 16'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      idle(1);
      check("t4_bcd_clr", bcd4, 16'h0000);
      check("t4_sat_clr", 16'(sat4), 16'd0);

      // 5: clear beats stop/start; stop beats a same-cycle tick
      step(1'b0, 1'b1, 1'b0, 1'b0);
      ticks(1);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      idle(1);
      check("t5_all_bcd", bcd4, 16'h0000);
      check("t5_all_run", 16'(run4), 16'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      ticks(3);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      idle(1);
      check("t5_stoptick_bcd", bcd4, 16'h0000);
      check("t5_stoptick_en", 16'(en4), 16'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      ticks(1);
      idle(1);
      check("t5_resume_bcd", bcd4, 16'h0001);

      // 6: reset mid-run, then a 100 ms-per-tenth instance
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      ticks(168);
      idle(1);
      check("t6_bcd_0042", bcd4, 16'h0042);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      idle(1);
      check("t6_rst_bcd", bcd4, 16'h0000);
      check("t6_rst_en", 16'(en4), 16'd0);
      check("t6_rst_run", 16'(run4), 16'd0);
      check("t6_rst_pulse", 16'(pulse4), 16'd0);
      rst = 1'b1;
      step(1'b0, 1'b1, 1'b0, 1'b0);
      ticks(99);
      idle(1);
      check("t6_100_at99", bcd100, 16'h0000);
      check("t6_4_at99", bcd4, 16'h0024);
      ticks(1);
      idle(1);
      check("t6_100_at100", bcd100, 16'h0001);
      check("t6_4_at100", bcd4, 16'h0025);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
